long_wb_sequencer: RTL and testbench

Write-back sequencer on the write side of the multicycle ARM register file. Accepts one write-back request per handshake, either a 32-bit result (one destination) or a 64-bit long-multiply result (RdLo/RdHi pair). Serialises each request onto the file's single 32-bit write port, one register per cycle. Diverts any write to R15 onto a dedicated PC write port, since the file stores only R0–R14.

---
 rtl/arm_wb_pkg.sv | 23 ++
 rtl/long_wb_sequencer.sv | 87 ++++++++
 tb/tb_long_wb_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/arm_wb_pkg.sv
// Shared types for the register-file write-back path: sequencer states,
// the PC register index and the captured request bundle.
package arm_wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 4;

  localparam logic [3:0] REG_PC = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic                 long;
    logic [WB_AW-1:0]     lo_addr;
    logic [WB_AW-1:0]     hi_addr;
    logic [2*WB_DW-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/long_wb_sequencer.sv
// Serialises 32-bit and 64-bit write-back requests onto the single register
// file write port, diverting R15 writes to the dedicated PC port.
//
// state | meaning
// IDLE  | nothing captured, ready for a request
// WR_LO | writing low word (or the only word) to the captured lo address
// WR_HI | writing high word of a long request to the captured hi address
module long_wb_sequencer
  import arm_wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_long,
  input  logic [AW-1:0]   req_lo_addr,
  input  logic [AW-1:0]   req_hi_addr,
  input  logic [2*DW-1:0] req_data,
  output logic            we3,
  output logic [AW-1:0]   wa3,
  output logic [DW-1:0]   wd3,
  output logic            pc_we,
  output logic [DW-1:0]   pc_wd,
  output logic            busy
);

  wb_state_t     state;
  wb_req_t       cap;
  logic          accept;
  logic [AW-1:0] act_addr;
  logic [DW-1:0] act_word;

  // Ready only depends on registered state so acceptance never loops through req_valid.
  always_comb begin
    req_ready = (state == IDLE) || (state == WR_HI) || ((state == WR_LO) && !cap.long);
    accept    = req_valid && req_ready;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cap   <= '0;
    end else begin
      if (accept) begin
        cap.long    <= req_long;
        cap.lo_addr <= req_lo_addr;
        cap.hi_addr <= req_hi_addr;
        cap.data    <= req_data;
      end
      case (state)
        IDLE:    state <= accept ? WR_LO : IDLE;
        WR_LO: begin
          if (cap.long)    state <= WR_HI;
          else if (accept) state <= WR_LO;
          else             state <= IDLE;
        end
        WR_HI:   state <= accept ? WR_LO : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    act_addr = (state == WR_HI) ? cap.hi_addr : cap.lo_addr;
    act_word = (state == WR_HI) ? cap.data[2*DW-1:DW] : cap.data[DW-1:0];
    we3   = 1'b0;
    wa3   = '0;
    wd3   = '0;
    pc_we = 1'b0;
    pc_wd = '0;
    if (state != IDLE) begin
      if (act_addr == REG_PC) begin
        pc_we = 1'b1;
        pc_wd = act_word;
      end else begin
        we3 = 1'b1;
        wa3 = act_addr;
        wd3 = act_word;
      end
    end
  end

endmodule

// File: tb/tb_long_wb_sequencer.sv
// Bench for long_wb_sequencer: table of requests with a write scoreboard
// keyed by expected cycle, plus hand-written reset-abort sequence.
module tb_long_wb_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_long;
  logic [3:0]  req_lo_addr;
  logic [3:0]  req_hi_addr;
  logic [63:0] req_data;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic        busy;

  long_wb_sequencer #(.DW(32), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_long(req_long),
    .req_lo_addr(req_lo_addr), .req_hi_addr(req_hi_addr), .req_data(req_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_long;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [63:0] data;
    int          gap;
  } vec_t;

  typedef struct {
    int          cyc;
    bit          pc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;
  wr_t  exp_q[$];
  logic [31:0] rf_obs [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Write monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missing_write_addr", 64'(4'hx), 64'(e.addr));
    end
    if (we3 === 1'b1 || pc_we === 1'b1) begin
      chk("we_exclusive", {63'd0, we3 & pc_we}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {59'd0, pc_we, wa3}, 64'hx);
      end else begin
        e = exp_q.pop_front();
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
        chk("write_is_pc", {63'd0, pc_we}, {63'd0, e.pc});
        if (pc_we === 1'b1) begin
          chk("pc_wd", 64'(pc_wd), 64'(e.data));
        end else begin
          chk("wa3", 64'(wa3), 64'(e.addr));
          chk("wd3", 64'(wd3), 64'(e.data));
          rf_obs[wa3] = wd3;
        end
      end
    end
  end

  task automatic push_wr(input int c, input logic [3:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc = c; w.pc = (a == 4'hF); w.addr = a; w.data = d;
    exp_q.push_back(w);
  endtask

  // Called at a negedge; returns at the negedge of the request's final write cycle.
  task automatic drive(input vec_t v);
    chk("ready_at_drive", {63'd0, req_ready}, 64'd1);
    req_valid   = 1'b1;
    req_long    = v.is_long;
    req_lo_addr = v.lo;
    req_hi_addr = v.hi;
    req_data    = v.data;
    push_wr(cyc + 1, v.lo, v.data[31:0]);
    if (v.is_long) push_wr(cyc + 2, v.hi, v.data[63:32]);
    @(negedge clk);
    chk("busy_first_write", {63'd0, busy}, 64'd1);
    if (v.is_long) begin
      chk("ready_long_lo", {63'd0, req_ready}, 64'd0);
      // junk while not ready must be ignored
      req_long    = 1'($urandom);
      req_lo_addr = 4'($urandom);
      req_hi_addr = 4'($urandom);
      req_data    = {$urandom, $urandom};
      @(negedge clk);
    end
    chk("ready_final_write", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_data  = {$urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_ready", {63'd0, req_ready}, 64'd1);
      chk("idle_outs", {we3, pc_we, wa3, wd3 ^ pc_wd}, 38'd0);
      chk("idle_wd", {wd3, pc_wd}, 64'd0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs.push_back('{0, 4'd3,  4'd9,  64'h5555_6666_DEAD_BEEF, 1});
    vecs.push_back('{1, 4'd4,  4'd5,  64'h1234_5678_9ABC_DEF0, 1});
    vecs.push_back('{1, 4'd1,  4'd2,  64'hA1A1_A1A1_B2B2_B2B2, 0});
    vecs.push_back('{0, 4'd7,  4'd15, 64'hFFFF_FFFF_C3C3_C3C3, 2});
    vecs.push_back('{1, 4'd14, 4'd15, 64'hAAAA_0000_0000_5555, 1});
    vecs.push_back('{1, 4'd6,  4'd6,  64'h1111_1111_2222_2222, 1});
    vecs.push_back('{0, 4'd15, 4'd0,  64'h0000_0001_CAFE_F00D, 0});
    vecs.push_back('{0, 4'd0,  4'd15, 64'h0000_0002_0BAD_F00D, 0});
    vecs.push_back('{1, 4'd15, 4'd0,  64'h7777_8888_9999_AAAA, 0});
    vecs.push_back('{0, 4'd15, 4'd1,  64'h0000_0000_1357_9BDF, 1});

    reset = 1'b1; req_valid = 1'b0; req_long = 1'b0;
    req_lo_addr = '0; req_hi_addr = '0; req_data = '0;
    for (int i = 0; i < 16; i++) rf_obs[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_outs", {we3, pc_we, wa3}, 6'd0);
    chk("rst_wd", {wd3, pc_wd}, 64'd0);
    reset = 1'b0;
    idle(1);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end
    chk("r6_final", 64'(rf_obs[6]), 64'h1111_1111);
    chk("r3_value", 64'(rf_obs[3]), 64'hDEAD_BEEF);

    // Reset during WR_LO of a long request: hi write must never appear.
    req_valid = 1'b1; req_long = 1'b1;
    req_lo_addr = 4'd8; req_hi_addr = 4'd9; req_data = 64'hBBBB_BBBB_CCCC_CCCC;
    push_wr(cyc + 1, 4'd8, 32'hCCCC_CCCC);
    @(negedge clk);
    chk("abort_in_wr_lo_ready", {63'd0, req_ready}, 64'd0);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_ready", {63'd0, req_ready}, 64'd1);
    chk("abort_outs", {we3, pc_we, wa3}, 6'd0);
    reset = 1'b0;
    idle(2);
    chk("r9_untouched", 64'(rf_obs[9]), 64'd0);
    v = '{1, 4'd10, 4'd11, 64'h0F0F_0F0F_F0F0_F0F0, 1};
    drive(v);
    idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
